// File: rtl/aes_mask_seq_if.sv
// aes_mask_seq_if: request, masking-stage and downstream signals of the mask sequencer.
interface aes_mask_seq_if;
  logic start;
  logic [127:0] key;
  logic keylen;
  logic [127:0] block;
  logic busy;
  logic mask_init;
  logic mask_next;
  logic mask_finalize;
  logic [127:0] mask_key;
  logic mask_keylen;
  logic [127:0] mask_block;
  logic [127:0] mask_result;
  logic mask_valid;
  logic mask_ready;
  logic [127:0] mask_data;
  modport master (
    input start, key, keylen, block, mask_result, mask_ready,
    output busy, mask_init, mask_next, mask_finalize, mask_key, mask_keylen, mask_block, mask_valid, mask_data
  );
  modport slave (
    output start, key, keylen, block, mask_result, mask_ready,
    input busy, mask_init, mask_next, mask_finalize, mask_key, mask_keylen, mask_block, mask_valid, mask_data
  );
endinterface

// File: rtl/aes_mask_seq.sv
// aes_mask_seq: sequences init/next/finalize strobes to the AES masking stage and hands its result downstream.
module aes_mask_seq #(
  parameter int ROUNDS_128 = 10,
  parameter int ROUNDS_256 = 14
) (
  input logic clk,
  input logic reset,
  aes_mask_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, INIT, NEXT, FINAL, CAPTURE, VALID} state_t;
  localparam logic [3:0] LAST_128 = 4'(ROUNDS_128 - 1);
  localparam logic [3:0] LAST_256 = 4'(ROUNDS_256 - 1);
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [127:0] key_q, block_q, data_q;
  logic keylen_q;
  logic last;
  assign last = cnt == (keylen_q ? LAST_256 : LAST_128);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? INIT : IDLE;
      INIT:    state_nxt = NEXT;
      NEXT:    state_nxt = last ? FINAL : NEXT;
      FINAL:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = VALID;
      VALID:   state_nxt = bus.mask_ready ? IDLE : VALID;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      key_q <= '0;
      block_q <= '0;
      keylen_q <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        key_q <= bus.key;
        block_q <= bus.block;
        keylen_q <= bus.keylen;
        cnt <= '0;
      end
      if (state == NEXT) cnt <= cnt + 4'd1;
      // stage registered its finalize result at the edge closing FINAL
      if (state == CAPTURE) data_q <= bus.mask_result;
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.mask_init = state == INIT;
  assign bus.mask_next = state == NEXT;
  assign bus.mask_finalize = state == FINAL;
  assign bus.mask_valid = state == VALID;
  assign bus.mask_key = key_q;
  assign bus.mask_keylen = keylen_q;
  assign bus.mask_block = block_q;
  assign bus.mask_data = data_q;
endmodule

// File: tb/tb_aes_mask_seq.sv
// tb_aes_mask_seq: directed checks of strobe timing, capture, backpressure, ignored starts and reset.
module tb_aes_mask_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  aes_mask_seq_if m ();
  aes_mask_seq dut (.clk(clk), .reset(reset), .bus(m));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  bit ovr = 1'b0;
  logic [127:0] stub_res = '0;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BLK = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] OVR = 128'hdeadbeef_cafebabe_01234567_89abcdef;
  // masking-stage stub: registers key ^ ~block ^ {keylen} on finalize
  always @(posedge clk)
    if (m.mask_finalize) stub_res <= ovr ? OVR : (m.mask_key ^ ~m.mask_block ^ {128{m.mask_keylen}});
  assign m.mask_result = stub_res;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic kl, input logic [127:0] k, input logic [127:0] b,
                     input int n, input int hold, input bit inj, input logic [127:0] exp);
    int init_c = -1, fin_c = -1, valid_c = -1, hs_c = -1;
    int nn = 0, nfirst = -1, nlast = -1, overlap = 0, unstable = 0, idle_busy = 0;
    logic [127:0] d0 = '0;
    chk({tag, " busy@0"}, 128'(m.busy), 128'd0);
    m.start = 1'b1; m.key = k; m.block = b; m.keylen = kl; m.mask_ready = 1'b0;
    tick;
    m.start = 1'b0;
    for (int c = 1; c < 60 && hs_c < 0; c++) begin
      if (m.mask_init) init_c = c;
      if (m.mask_next) begin
        nn++;
        if (nfirst < 0) nfirst = c;
        nlast = c;
      end
      if (m.mask_finalize) fin_c = c;
      if (int'(m.mask_init) + int'(m.mask_next) + int'(m.mask_finalize) > 1) overlap++;
      if (!m.busy) idle_busy++;
      if (m.mask_valid) begin
        if (valid_c < 0) begin
          valid_c = c;
          d0 = m.mask_data;
        end else if (m.mask_data !== d0) unstable++;
      end
      m.mask_ready = m.mask_valid && (c - valid_c >= hold);
      if (m.mask_ready) hs_c = c;
      if (inj && (c == 5 || m.mask_ready)) begin
        m.start = 1'b1; m.key = '1; m.keylen = ~kl;
      end
      tick;
      m.start = 1'b0; m.key = k; m.keylen = kl; m.mask_ready = 1'b0;
    end
    chk({tag, " init cycle"}, 128'(init_c), 128'd1);
    chk({tag, " next count"}, 128'(nn), 128'(n));
    chk({tag, " first next"}, 128'(nfirst), 128'd2);
    chk({tag, " last next"}, 128'(nlast), 128'(n + 1));
    chk({tag, " finalize cycle"}, 128'(fin_c), 128'(n + 2));
    chk({tag, " valid cycle"}, 128'(valid_c), 128'(n + 4));
    chk({tag, " handshake cycle"}, 128'(hs_c), 128'(n + 4 + hold));
    chk({tag, " mask_data"}, d0, exp);
    chk({tag, " data stable"}, 128'(unstable), 128'd0);
    chk({tag, " strobe overlap"}, 128'(overlap), 128'd0);
    chk({tag, " busy gaps"}, 128'(idle_busy), 128'd0);
    chk({tag, " mask_key kept"}, m.mask_key, k);
    chk({tag, " mask_block kept"}, m.mask_block, b);
    chk({tag, " idle after hs busy"}, 128'(m.busy), 128'd0);
    chk({tag, " idle after hs valid"}, 128'(m.mask_valid), 128'd0);
  endtask
  initial begin
    m.start = 1'b0; m.key = '0; m.block = '0; m.keylen = 1'b0; m.mask_ready = 1'b0;
    tick; tick;
    chk("rst busy", 128'(m.busy), 128'd0);
    chk("rst strobes", 128'({m.mask_init, m.mask_next, m.mask_finalize}), 128'd0);
    chk("rst valid", 128'(m.mask_valid), 128'd0);
    chk("rst data", m.mask_data, 128'd0);
    chk("rst key", m.mask_key, 128'd0);
    reset = 1'b0;
    run("aes128", 1'b0, KEY, BLK, 10, 0, 1'b0, 128'hffefdfcfbfaf9f8f7f6f5f4f3f2f1f0f);
    // reset mid-NEXT after a completed operation so data and operands are nonzero
    m.start = 1'b1; m.key = KEY; m.block = BLK; m.keylen = 1'b1;
    tick;
    m.start = 1'b0;
    tick; tick; tick; tick;
    chk("pre-reset next", 128'(m.mask_next), 128'd1);
    reset = 1'b1;
    tick; tick; tick;
    reset = 1'b0;
    chk("mid rst busy", 128'(m.busy), 128'd0);
    chk("mid rst strobes", 128'({m.mask_init, m.mask_next, m.mask_finalize}), 128'd0);
    chk("mid rst valid", 128'(m.mask_valid), 128'd0);
    chk("mid rst data", m.mask_data, 128'd0);
    chk("mid rst key", m.mask_key, 128'd0);
    chk("mid rst block", m.mask_block, 128'd0);
    chk("mid rst keylen", 128'(m.mask_keylen), 128'd0);
    run("aes256", 1'b1, KEY, BLK, 14, 0, 1'b0, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("aes256 keylen", 128'(m.mask_keylen), 128'd1);
    ovr = 1'b1;
    run("bp+ignored", 1'b0, KEY, BLK, 10, 5, 1'b1, OVR);
    ovr = 1'b0;
    run("after hs", 1'b1, '1, BLK, 14, 0, 1'b0, 128'hffeeddccbbaa99887766554433221100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
